// File: rtl/fpga_status_tx.sv
// Per-channel status read-back responder: synchronizes status words, builds a
// snapshot/change message per channel and serves it byte by byte (show-ahead).
// Optional STATUS_HDR_EN adds a header byte carrying dropped/source/seq.
module fpga_status_tx #(
  parameter int NCH         = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [NCH*8-1:0] status_bus,
  input  logic [NCH-1:0]   snap_bus,
  input  logic [NCH-1:0]   auto_en,
  input  logic [NCH-1:0]   rdreq_bus,
  output logic [NCH-1:0]   have_msg_bus,
  output logic [NCH*8-1:0] slave_data_bus,
  output logic [NCH*8-1:0] len_bus,
  output logic [7:0]       drop_cnt
);

`ifdef STATUS_HDR_EN
  localparam logic [7:0] MSG_LEN = 8'd2;
`else
  localparam logic [7:0] MSG_LEN = 8'd1;
`endif

  logic [NCH*8-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0]   drop_ev;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [15:0]      drop_sum;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= status_bus;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [7:0] sync_w;
    logic       have_q, have_d;
    logic [7:0] last_q, last_d;
    logic [7:0] stat_q, stat_d;
    logic       pop, last_byte, free, evt, accept;

    assign sync_w = sync_q[SYNC_STAGES-1][8*i +: 8];

`ifdef STATUS_HDR_EN
    logic       ptr_q, ptr_d;
    logic       drop_q, drop_d;
    logic [3:0] seq_q, seq_d;
    logic [7:0] hdr_q, hdr_d;
    assign last_byte = ptr_q;
`else
    assign last_byte = 1'b1;
`endif

    assign pop        = rdreq_bus[i] & have_q;
    // A buffer being emptied this cycle can take the new message immediately.
    assign free       = !have_q || (pop && last_byte);
    assign evt        = snap_bus[i] || (auto_en[i] && (sync_w != last_q));
    assign accept     = evt && free;
    assign drop_ev[i] = snap_bus[i] && !free;

    always_comb begin
      have_d = have_q;
      last_d = last_q;
      stat_d = stat_q;
`ifdef STATUS_HDR_EN
      ptr_d  = ptr_q;
      seq_d  = seq_q;
      drop_d = drop_q;
      hdr_d  = hdr_q;
`endif
      if (accept) begin
        have_d = 1'b1;
        last_d = sync_w;
        stat_d = sync_w;
`ifdef STATUS_HDR_EN
        ptr_d  = 1'b0;
        seq_d  = seq_q + 4'd1;
        drop_d = 1'b0;
        hdr_d  = {drop_q, !snap_bus[i], 2'b00, seq_q + 4'd1};
`endif
      end else if (pop) begin
        if (last_byte) have_d = 1'b0;
`ifdef STATUS_HDR_EN
        ptr_d = !last_byte;
`endif
      end
`ifdef STATUS_HDR_EN
      if (drop_ev[i]) drop_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        have_q <= 1'b0;
        last_q <= '0;
        stat_q <= '0;
`ifdef STATUS_HDR_EN
        ptr_q  <= 1'b0;
        seq_q  <= '0;
        drop_q <= 1'b0;
        hdr_q  <= '0;
`endif
      end else begin
        have_q <= have_d;
        last_q <= last_d;
        stat_q <= stat_d;
`ifdef STATUS_HDR_EN
        ptr_q  <= ptr_d;
        seq_q  <= seq_d;
        drop_q <= drop_d;
        hdr_q  <= hdr_d;
`endif
      end
    end

    assign have_msg_bus[i] = have_q;
`ifdef STATUS_HDR_EN
    assign len_bus[8*i +: 8]        = have_q ? (MSG_LEN - {7'd0, ptr_q}) : 8'd0;
    assign slave_data_bus[8*i +: 8] = !have_q ? 8'd0 : (ptr_q ? stat_q : hdr_q);
`else
    assign len_bus[8*i +: 8]        = have_q ? MSG_LEN : 8'd0;
    assign slave_data_bus[8*i +: 8] = have_q ? stat_q : 8'd0;
`endif
  end

  always_comb begin
    drop_sum = {8'd0, drop_cnt_q};
    for (int i = 0; i < NCH; i++) drop_sum = drop_sum + {15'd0, drop_ev[i]};
    drop_cnt_d = (drop_sum > 16'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fpga_status_tx.sv
// Bench for fpga_status_tx: message-level reference model plus directed and
// random stimulus; builds with or without STATUS_HDR_EN.
module tb_fpga_status_tx;
  localparam int NCH = 10;
  localparam int SS  = 2;
`ifdef STATUS_HDR_EN
  localparam int ML = 2;
`else
  localparam int ML = 1;
`endif

  logic             clk = 1'b0;
  logic             n_rst = 1'b1;
  logic [NCH*8-1:0] status_bus = '0;
  logic [NCH-1:0]   snap_bus = '0, auto_en = '0, rdreq_bus = '0;
  logic [NCH-1:0]   have_msg_bus;
  logic [NCH*8-1:0] slave_data_bus, len_bus;
  logic [7:0]       drop_cnt;

  fpga_status_tx #(.NCH(NCH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .n_rst(n_rst), .status_bus(status_bus), .snap_bus(snap_bus),
    .auto_en(auto_en), .rdreq_bus(rdreq_bus), .have_msg_bus(have_msg_bus),
    .slave_data_bus(slave_data_bus), .len_bus(len_bus), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each channel holds a message as bytes plus a count of bytes left.
  logic [NCH*8-1:0] hist [$];
  logic [7:0] m_b0 [NCH], m_b1 [NCH], m_last [NCH];
  int         m_rem [NCH], m_seq [NCH];
  bit         m_drp [NCH];
  int         m_dcnt;
  logic [NCH*8-1:0] m_sy;
  logic [7:0] m_s;
  bit m_pop, m_free, m_snap, m_auto;

  function automatic logic [7:0] m_byte(int i);
    int idx;
    idx = ML - m_rem[i];
    if (m_rem[i] == 0) return 8'h00;
    return (idx == 0) ? m_b0[i] : m_b1[i];
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hist.delete();
      for (int s = 0; s < SS; s++) hist.push_back('0);
      for (int i = 0; i < NCH; i++) begin
        m_b0[i] = 0; m_b1[i] = 0; m_last[i] = 0; m_rem[i] = 0; m_seq[i] = 0; m_drp[i] = 0;
      end
      m_dcnt = 0;
    end else begin
      m_sy = hist[SS-1];
      for (int i = 0; i < NCH; i++) begin
        m_s    = m_sy[8*i +: 8];
        m_pop  = rdreq_bus[i] && (m_rem[i] > 0);
        m_free = (m_rem[i] == 0) || (m_pop && m_rem[i] == 1);
        m_snap = snap_bus[i];
        m_auto = auto_en[i] && (m_s != m_last[i]);
        if (m_pop) m_rem[i]--;
        if ((m_snap || m_auto) && m_free) begin
          m_seq[i] = (m_seq[i] + 1) % 16;
          if (ML == 2) begin
            m_b0[i] = {m_drp[i], !m_snap, 2'b00, 4'(m_seq[i])};
            m_b1[i] = m_s;
          end else begin
            m_b0[i] = m_s;
          end
          m_rem[i]  = ML;
          m_last[i] = m_s;
          m_drp[i]  = 0;
        end else if (m_snap) begin
          m_drp[i] = 1;
          if (m_dcnt < 255) m_dcnt++;
        end
      end
      hist.push_front(status_bus);
      void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("have[%0d]", i), int'(have_msg_bus[i]), int'(m_rem[i] > 0));
        chk($sformatf("len[%0d]", i), int'(len_bus[8*i +: 8]), m_rem[i]);
        chk($sformatf("data[%0d]", i), int'(slave_data_bus[8*i +: 8]), int'(m_byte(i)));
      end
      chk("drop_cnt", int'(drop_cnt), m_dcnt);
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap1(int ch);
    snap_bus[ch] = 1'b1; cyc(); snap_bus[ch] = 1'b0;
  endtask

  task automatic pop1(int ch);
    rdreq_bus[ch] = 1'b1; cyc(); rdreq_bus[ch] = 1'b0;
  endtask

  task automatic rnd(int n, int sp, int rp);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < NCH; i++) begin
        snap_bus[i]  = ($urandom_range(15) < sp);
        rdreq_bus[i] = ($urandom_range(15) < rp);
        if ($urandom_range(31) == 0) status_bus[8*i +: 8] = 8'($urandom);
        if ($urandom_range(15) == 0) auto_en[i] = ~auto_en[i];
      end
      cyc();
    end
    snap_bus = '0;
    rdreq_bus = '0;
  endtask

  initial begin
    status_bus[7:0] = 8'hA5;
    #1 n_rst = 1'b0;
    chk_en = 1;
    cyc(3);
    n_rst = 1'b1;
    chk("rst_have", int'(have_msg_bus), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_len0", int'(len_bus[7:0]), 0);

    // snapshot on ch0 and full drain
    cyc(2);
    snap1(0);
    chk("t1_have", int'(have_msg_bus[0]), 1);
    chk("t1_len", int'(len_bus[7:0]), ML);
    chk("t1_b0", int'(slave_data_bus[7:0]), (ML == 2) ? 8'h01 : 8'hA5);
    if (ML == 2) begin
      pop1(0);
      chk("t1_b1", int'(slave_data_bus[7:0]), 8'hA5);
      chk("t1_len1", int'(len_bus[7:0]), 1);
    end
    pop1(0);
    chk("t1_empty", int'(have_msg_bus[0]), 0);
    chk("t1_data0", int'(slave_data_bus[7:0]), 0);

    // auto change on ch3
    auto_en[3] = 1'b1;
    status_bus[31:24] = 8'h3C;
    cyc(2);
    chk("t2_early", int'(have_msg_bus[3]), 0);
    cyc();
    chk("t2_have", int'(have_msg_bus[3]), 1);
    chk("t2_b0", int'(slave_data_bus[31:24]), (ML == 2) ? 8'h41 : 8'h3C);
    repeat (ML) pop1(3);
    cyc(5);
    chk("t2_stable", int'(have_msg_bus[3]), 0);
    auto_en[3] = 1'b0;

    // drops on ch5
    snap1(5);
    snap1(5);
    snap1(5);
    chk("t3_dcnt", int'(drop_cnt), 2);
    repeat (ML) pop1(5);
    snap1(5);
    chk("t3_hdr_drop", int'(slave_data_bus[47:40]), (ML == 2) ? 8'h82 : 8'h00);
    repeat (ML) pop1(5);
    snap1(5);
    chk("t3_hdr_clr", int'(slave_data_bus[47:40]), (ML == 2) ? 8'h03 : 8'h00);
    repeat (ML) pop1(5);

    // final-byte pop coincident with snap on ch1
    snap1(1);
    if (ML == 2) pop1(1);
    rdreq_bus[1] = 1'b1; snap_bus[1] = 1'b1;
    cyc();
    rdreq_bus[1] = 1'b0; snap_bus[1] = 1'b0;
    chk("t4_have", int'(have_msg_bus[1]), 1);
    chk("t4_len", int'(len_bus[15:8]), ML);
    chk("t4_b0", int'(slave_data_bus[15:8]), (ML == 2) ? 8'h02 : 8'h00);
    repeat (ML) pop1(1);

    // seq wrap on ch7
    for (int k = 0; k < 17; k++) begin
      snap1(7);
      chk("t5_seq", int'(slave_data_bus[63:56]), (ML == 2) ? ((k + 1) % 16) : 0);
      repeat (ML) pop1(7);
    end
    rdreq_bus = '1;
    cyc();
    rdreq_bus = '0;
    chk("t5_idle_have", int'(have_msg_bus), 0);
    chk("t5_idle_dcnt", int'(drop_cnt), 2);

    // random traffic, then heavy snaps to saturate drop_cnt
    rnd(1500, 1, 6);
    rnd(600, 8, 1);
    chk("sat_dcnt", int'(drop_cnt), 255);
    rnd(300, 2, 8);

    // reset mid-message
    auto_en = '0;
    cyc(4);
    repeat (ML) pop1(2);
    snap1(2);
    if (ML == 2) pop1(2);
    #2 n_rst = 1'b0;
    #1;
    chk("t6_have", int'(have_msg_bus), 0);
    chk("t6_len", int'(len_bus), 0);
    chk("t6_dcnt", int'(drop_cnt), 0);
    cyc();
    n_rst = 1'b1;
    cyc(SS + 1);
    snap1(2);
    chk("t6_len2", int'(len_bus[23:16]), ML);
    chk("t6_b0", int'(slave_data_bus[23:16]), (ML == 2) ? 8'h01 : int'(status_bus[23:16]));
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
